// File: rtl/keypad_defs_pkg.sv
// Shared keypad definitions: event word layout, debounce default, IO word offsets.
package keypad_defs;

  localparam int unsigned NUM_KEYS      = 8;
  localparam int unsigned KEY_IDX_W     = 3;
  localparam int unsigned EVT_W         = 8;
  localparam int unsigned EVT_PRESS_BIT = 7;
  localparam int unsigned EVT_IDX_MSB   = 2;
  localparam int unsigned EVT_IDX_LSB   = 0;
  localparam int unsigned COUNT_W       = 4;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 20000;

  // Word offsets of this block inside the IO memory bank
  localparam logic [1:0] IO_OFS_STATE   = 2'd0;
  localparam logic [1:0] IO_OFS_EVENT   = 2'd1;
  localparam logic [1:0] IO_OFS_CNT_OVF = 2'd2;

  typedef struct packed {
    logic                 press;
    logic [3:0]           rsvd;
    logic [KEY_IDX_W-1:0] idx;
  } key_event_t;

  function automatic logic [KEY_IDX_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
    logic [KEY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic key_event_t make_event(input logic press, input logic [KEY_IDX_W-1:0] idx);
    key_event_t e;
    e       = '0;
    e.press = press;
    e.idx   = idx;
    return e;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One keypad line: 2-flop synchronizer followed by a counter debounce holding the clean level.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic level_o
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronized input disagrees with the clean level
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/keypad_event_unit.sv
// Keypad conditioning: 8 debounced lines, edge capture, arbitrated push into a FWFT event FIFO.
// Optional release events are enabled by defining KEYPAD_RELEASE_EVT_EN.
module keypad_event_unit
  import keypad_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned CNT_W           = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_KEYS-1:0]  keypad,
  input  logic                 pop,
  input  logic                 clearOvf,
  output logic [NUM_KEYS-1:0]  keyState,
  output logic [EVT_W-1:0]     eventData,
  output logic                 eventValid,
  output logic [COUNT_W-1:0]   eventCount,
  output logic                 overflow
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_prev_q;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] press_pend_q, press_pend_d, press_clr;
  logic                overflow_q, overflow_d, ovf_set;

  key_event_t          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                empty, full, pop_eff, room, push;
  key_event_t          push_evt;
  logic [PTR_W-1:0]    occupancy;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .key_i  (keypad[i]),
      .level_o(key_level[i])
    );
  end

  assign rise      = key_level & ~key_prev_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_eff   = pop & ~empty;
  assign room      = ~full | pop_eff;
  assign occupancy = wr_ptr_q - rd_ptr_q;

`ifdef KEYPAD_RELEASE_EVT_EN
  logic [NUM_KEYS-1:0] fall;
  logic [NUM_KEYS-1:0] rel_pend_q, rel_pend_d, rel_clr;

  assign fall = ~key_level & key_prev_q;

  // Presses first, then releases; lowest line index wins within a class
  always_comb begin
    push      = 1'b0;
    push_evt  = '0;
    press_clr = '0;
    rel_clr   = '0;
    if ((|press_pend_q) && room) begin
      push                          = 1'b1;
      push_evt                      = make_event(1'b1, lowest_idx(press_pend_q));
      press_clr[push_evt.idx]       = 1'b1;
    end else if ((|rel_pend_q) && room) begin
      push                          = 1'b1;
      push_evt                      = make_event(1'b0, lowest_idx(rel_pend_q));
      rel_clr[push_evt.idx]         = 1'b1;
    end
  end

  assign rel_pend_d = (rel_pend_q & ~rel_clr) | fall;
  assign ovf_set    = (|(rise & press_pend_q & ~press_clr)) | (|(fall & rel_pend_q & ~rel_clr));

  always_ff @(posedge clk) begin
    if (reset) rel_pend_q <= '0;
    else       rel_pend_q <= rel_pend_d;
  end
`else
  // Presses only; lowest line index wins
  always_comb begin
    push      = 1'b0;
    push_evt  = '0;
    press_clr = '0;
    if ((|press_pend_q) && room) begin
      push                    = 1'b1;
      push_evt                = make_event(1'b1, lowest_idx(press_pend_q));
      press_clr[push_evt.idx] = 1'b1;
    end
  end

  assign ovf_set = |(rise & press_pend_q & ~press_clr);
`endif

  // A new edge re-arms a pending bit even in the cycle it is being pushed
  assign press_pend_d = (press_pend_q & ~press_clr) | rise;
  assign overflow_d   = ovf_set | (overflow_q & ~clearOvf);
  assign wr_ptr_d     = push    ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d     = pop_eff ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_prev_q   <= '0;
      press_pend_q <= '0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      key_prev_q   <= key_level;
      press_pend_q <= press_pend_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only visible while the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_evt;
  end

  assign keyState   = key_level;
  assign eventValid = ~empty;
  assign eventData  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign eventCount = COUNT_W'(occupancy);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_event_unit.sv
// Directed bench for keypad_event_unit with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
module tb_keypad_event_unit;

  logic       clk;
  logic       reset;
  logic [7:0] keypad;
  logic       pop;
  logic       clearOvf;
  logic [7:0] keyState;
  logic [7:0] eventData;
  logic       eventValid;
  logic [3:0] eventCount;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  keypad_event_unit #(
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH     (4),
    .CNT_W          (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .keypad    (keypad),
    .pop       (pop),
    .clearOvf  (clearOvf),
    .keyState  (keyState),
    .eventData (eventData),
    .eventValid(eventValid),
    .eventCount(eventCount),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_once();
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
  endtask

  task automatic do_reset();
    keypad   = 8'h00;
    pop      = 1'b0;
    clearOvf = 1'b0;
    reset    = 1'b1;
    tick(2);
    reset    = 1'b0;
  endtask

  initial begin
    keypad   = 8'h00;
    pop      = 1'b0;
    clearOvf = 1'b0;
    reset    = 1'b1;
    tick(2);
    check("rst_keystate", keyState, 8'h00);
    check("rst_data", eventData, 8'h00);
    check("rst_valid", eventValid, 1'b0);
    check("rst_count", eventCount, 4'd0);
    check("rst_ovf", overflow, 1'b0);
    reset = 1'b0;

    // single press: keyState after 6 clk, event 2 clk later
    keypad = 8'h01;
    tick(5);
    check("t1_keystate_5clk", keyState, 8'h00);
    tick(1);
    check("t1_keystate_6clk", keyState, 8'h01);
    tick(1);
    check("t1_valid_7clk", eventValid, 1'b0);
    tick(1);
    check("t1_valid_8clk", eventValid, 1'b1);
    check("t1_data", eventData, 8'h80);
    check("t1_count", eventCount, 4'd1);
    pop_once();
    check("t1_valid_popped", eventValid, 1'b0);
    check("t1_count_popped", eventCount, 4'd0);
    pop_once();
    check("t1_pop_empty", eventCount, 4'd0);

    // 3-clk glitch is rejected
    do_reset();
    keypad = 8'h08;
    tick(3);
    keypad = 8'h00;
    tick(12);
    check("t2_keystate", keyState, 8'h00);
    check("t2_valid", eventValid, 1'b0);
    check("t2_ovf", overflow, 1'b0);

    // two simultaneous presses, lowest index first
    do_reset();
    keypad = 8'h05;
    tick(8);
    check("t3_valid", eventValid, 1'b1);
    check("t3_data0", eventData, 8'h80);
    check("t3_count1", eventCount, 4'd1);
    tick(1);
    check("t3_count2", eventCount, 4'd2);
    pop_once();
    check("t3_data1", eventData, 8'h82);
    check("t3_count_after_pop", eventCount, 4'd1);
    pop_once();
    check("t3_count_empty", eventCount, 4'd0);

    // six presses into a 4-deep FIFO; two held pending
    do_reset();
    for (int k = 0; k < 6; k++) begin
      keypad = keypad | (8'h01 << k);
      tick(2);
    end
    tick(20);
    check("t4_count_full", eventCount, 4'd4);
    check("t4_head", eventData, 8'h80);
    check("t4_ovf", overflow, 1'b0);
    pop_once();
    check("t4_pop1_head", eventData, 8'h81);
    check("t4_pop1_count", eventCount, 4'd4);
    pop_once();
    check("t4_pop2_head", eventData, 8'h82);
    check("t4_pop2_count", eventCount, 4'd4);
    for (int i = 0; i < 3; i++) begin
      pop_once();
      check("t4_drain_head", eventData, 32'h83 + 32'(i));
      check("t4_drain_count", eventCount, 32'(3 - i));
    end
    check("t4_ovf_end", overflow, 1'b0);

    // coalesced press on a held line raises overflow; clear; reset mid-debounce
    do_reset();
    keypad = 8'h0F;
    tick(14);
    check("t5_count_full", eventCount, 4'd4);
    keypad = 8'h8F;
    tick(10);
    keypad = 8'h0F;
    tick(10);
    check("t5_ovf_before", overflow, 1'b0);
    keypad = 8'h8F;
    tick(10);
    check("t5_ovf_set", overflow, 1'b1);
    clearOvf = 1'b1;
    tick(1);
    clearOvf = 1'b0;
    check("t5_ovf_cleared", overflow, 1'b0);
    keypad = 8'h0F;
    tick(10);
    keypad = 8'h8F;
    tick(10);
    check("t5_ovf_reset_again", overflow, 1'b1);
    keypad = 8'h00;
    tick(3);
    reset = 1'b1;
    tick(1);
    check("t5_rst_keystate", keyState, 8'h00);
    check("t5_rst_data", eventData, 8'h00);
    check("t5_rst_valid", eventValid, 1'b0);
    check("t5_rst_count", eventCount, 4'd0);
    check("t5_rst_ovf", overflow, 1'b0);
    reset = 1'b0;

    // press then release key 2
    do_reset();
    keypad = 8'h04;
    tick(10);
    keypad = 8'h00;
    tick(10);
    check("t6_keystate", keyState, 8'h00);
    check("t6_head", eventData, 8'h82);
`ifdef KEYPAD_RELEASE_EVT_EN
    check("t6_count", eventCount, 4'd2);
    pop_once();
    check("t6_release_valid", eventValid, 1'b1);
    check("t6_release_data", eventData, 8'h02);
    pop_once();
    check("t6_empty", eventValid, 1'b0);
`else
    check("t6_count", eventCount, 4'd1);
    pop_once();
    check("t6_empty", eventValid, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_event_unit.md
Name: keypad_event_unit

Overview:
- Conditions the 8 active-high keypad lines ahead of the memory-mapped IO block and produces clean, queued key events for software polling.
- Per-line stages: 2-flop synchronizer, then counter debounce, then edge detect.
- Edges are serialized into a first-word-fall-through event FIFO. The IO memory bank reads and pops that FIFO.
- Runs on the fast data-memory clock domain.

Parameters:
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles required before the debounced level changes. Minimum 2.
- FIFO_DEPTH, 8: event FIFO entries. Must be a power of 2, minimum 2.
- CNT_W, 15: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  fast clock.
- reset  in  1  synchronous, active-high.
- keypad  in  8  raw key lines, asynchronous, 1 = pressed.
- pop  in  1  one-cycle pulse that removes the FIFO head.
- clearOvf  in  1  one-cycle pulse that clears the overflow flag.
- keyState  out  8  debounced key levels.
- eventData  out  8  FIFO head. Format: bit7 = 1 press / 0 release; bits6:3 = 0; bits2:0 = key index.
- eventValid  out  1  FIFO non-empty.
- eventCount  out  4  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky event-loss flag.

Behaviour:
- Reset is synchronous, active-high, on clk. On reset:
  - Synchronizers, keyState, debounce counters, pending masks, FIFO pointers and overflow all clear to 0.
  - eventData = 0, eventValid = 0, eventCount = 0.
  - A reset asserted mid-debounce or with a non-empty FIFO discards everything.
- Synchronizer: s2[i] lags keypad[i] by 2 clk.
- Debounce, per line i:
  - If s2[i] == keyState[i], the counter is cleared.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and s2[i] still differs, keyState[i] toggles and the counter clears.
  - Net latency from a keypad change to keyState = 2 + DEBOUNCE_CYCLES clk.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Edge capture:
  - keyState[i] rising sets pressPend[i].
  - keyState[i] falling sets relPend[i] (only when the optional feature is enabled).
  - A new edge on a line whose pending bit is already set sets overflow. The event is coalesced, not duplicated.
- Push arbitration, at most one push per cycle:
  - Push occurs when any pending bit is set and the FIFO is not full, or when the FIFO is full and pop is asserted in the same cycle.
  - Press events have priority over release events. Within a class, the lowest index wins.
  - The pushed pending bit clears in the same cycle.
  - While the FIFO is full with no pop, pending bits are held. No loss occurs other than by coalescing.
- FIFO:
  - First-word-fall-through: eventData shows the head combinationally from the storage register. A pushed event is visible on eventData/eventValid the cycle after the push.
  - pop while empty is ignored and the pointers do not change.
  - Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the remaining bits are equal.
- Overflow:
  - Sticky until clearOvf or reset.
  - If clearOvf and a new overflow condition occur in the same cycle, the set wins.
- Event from a key press to eventValid = 2 + DEBOUNCE_CYCLES + 2 clk when the FIFO is empty and no other events are pending.

Optional Feature:
- KEYPAD_RELEASE_EVT_EN defined: release edges queue events with bit7 = 0, arbitrated after presses.
- KEYPAD_RELEASE_EVT_EN undefined:
  - relPend logic is absent.
  - Only press events are queued, so bit7 of eventData is always 1 whenever eventValid is high.
  - keyState still tracks releases.

Decomposition:
- Shared package/header keypad_defs holds:
  - event field positions (EVT_PRESS_BIT = 7, EVT_IDX_MSB = 2, EVT_IDX_LSB = 0);
  - the DEBOUNCE_CYCLES default;
  - the IO word offsets used by the IO memory (state, event, count/overflow).
- One natural sub-module, key_debounce: a single line with synchronizer, counter and keyState bit, instantiated 8 times.
- FIFO and arbitration stay in the top.

Test Plan (DEBOUNCE_CYCLES = 4, FIFO_DEPTH = 4):
- keypad = 0x01 held → keyState = 0x01 exactly 6 clk later; eventValid high 2 clk after that; eventData = 0x80; pulse pop → eventValid = 0, eventCount = 0.
- keypad[3] pulses high for 3 clk then low → keyState stays 0x00, no event, overflow = 0.
- keypad = 0x05 asserted in the same cycle → two events in order 0x80 then 0x82; eventCount reaches 2.
- Press keys 0..5 sequentially with no pops → eventCount holds at 4. Two pending events are held until two pops, then they appear as 0x84 and 0x85. overflow = 0.
- With the FIFO full, press/release/press key 7 → overflow = 1. clearOvf pulse → overflow = 0. Assert reset mid-debounce → all outputs 0 next cycle.
- With KEYPAD_RELEASE_EVT_EN defined: press then release key 2 → events 0x82 then 0x02. Undefined: only 0x82 is queued.
